// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: decodes core loads/stores into word-aligned memory
// requests, waits for the response with a timeout, and extends returned load data.
module riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       size_q, size_d;
    logic [1:0]       off_q, off_d;
    logic             we_q, we_d;

    logic             size_legal;
    logic             misaligned;
    logic [3:0]       be_raw;
    logic [31:0]      rd_shift;
    logic [31:0]      load_data;

    // Size code bits [1:0] give the width, bit [2] selects zero-extension.
    always_comb begin
        case (core_size_i)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_legal = 1'b1;
            default:                                size_legal = 1'b0;
        endcase
        misaligned = ((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                     ((core_size_i[1:0] == 2'b10) && (core_addr_i[1:0] != 2'b00));
    end

    always_comb begin
        case (core_size_i[1:0])
            2'b00: begin
                be_raw   = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
            end
            2'b01: begin
                be_raw   = 4'b0011 << core_addr_i[1:0];
                mem_wd_o = {2{core_wd_i[15:0]}};
            end
            2'b10: begin
                be_raw   = 4'b1111;
                mem_wd_o = core_wd_i;
            end
            default: begin
                be_raw   = 4'b0000;
                mem_wd_o = core_wd_i;
            end
        endcase
    end

    assign mem_addr_o = {core_addr_i[31:2], 2'b00};
    assign mem_we_o   = core_we_i;

    // Completion uses only the latched size/offset, never the live core inputs.
    assign rd_shift = mem_rd_i >> {off_q, 3'b000};

    always_comb begin
        case (size_q[1:0])
            2'b00:   load_data = {{24{rd_shift[7] & ~size_q[2]}}, rd_shift[7:0]};
            2'b01:   load_data = {{16{rd_shift[15] & ~size_q[2]}}, rd_shift[15:0]};
            default: load_data = mem_rd_i;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default up front so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        off_d        = off_q;
        we_d         = we_q;
        mem_req_o    = 1'b0;
        mem_be_o     = 4'b0000;
        core_stall_o = 1'b0;
        core_err_o   = 1'b0;
        core_rd_o    = 32'h0;

        if (!rst_i) begin
            case (state_q)
                S_IDLE: begin
                    if (core_req_i) begin
                        if (size_legal && !misaligned) begin
                            mem_req_o    = 1'b1;
                            mem_be_o     = be_raw;
                            core_stall_o = 1'b1;
                            size_d       = core_size_i;
                            off_d        = core_addr_i[1:0];
                            we_d         = core_we_i;
                            cnt_d        = '0;
                            state_d      = S_WAIT;
                        end else begin
                            core_err_o = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ready_i) begin
                        core_rd_o = we_q ? 32'h0 : load_data;
                        state_d   = S_IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        core_err_o = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        core_stall_o = 1'b1;
                        cnt_d        = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            size_q  <= 3'b000;
            off_q   <= 2'b00;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            off_q   <= off_d;
            we_q    <= we_d;
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed scenarios plus randomized accesses
// compared against an arithmetic reference model of the load/store rules.
module tb_riscv_lsu;

    localparam int unsigned T = 15;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    riscv_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .core_err_o   (core_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes, 0 for an illegal size code.
    function automatic int unsigned size_bytes(input logic [2:0] s);
        case (s)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] s, input logic [31:0] a);
        int unsigned nb = size_bytes(s);
        int unsigned m  = ((32'd1 << nb) - 1) << (a % 4);
        return m;
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] s, input logic [31:0] wd);
        int unsigned nb = size_bytes(s);
        if (nb == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (nb == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] s, input logic [31:0] a,
                                               input logic [31:0] word);
        int unsigned nb = size_bytes(s);
        logic [31:0] v  = word >> (8 * (a % 4));
        if (nb == 1) begin
            v = v & 32'hFF;
            if (s < 3'd4 && v >= 32'd128) v = v - 32'd256;
        end else if (nb == 2) begin
            v = v & 32'hFFFF;
            if (s < 3'd4 && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    // One complete access starting in an IDLE cycle; lat = WAIT cycles with mem_ready_i low.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] word, input int lat);
        int unsigned nb;
        logic        legal;
        logic        done;
        nb    = size_bytes(size);
        legal = (nb != 0) && ((addr % nb) == 0);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rd_i    = $urandom;
        @(negedge clk_i);
        check("mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        check("mem_we", 32'(mem_we_o), 32'(we));
        check("rd_idle", core_rd_o, 32'h0);
        if (!legal) begin
            check("err_req", 32'(mem_req_o), 32'h0);
            check("err_stall", 32'(core_stall_o), 32'h0);
            check("err_pulse", 32'(core_err_o), 32'h1);
            check("err_be", 32'(mem_be_o), 32'h0);
            @(posedge clk_i);
            #1;
            core_req_i = 1'b0;
            return;
        end
        check("mem_wd", mem_wd_o, model_wd(size, wd));
        check("req", 32'(mem_req_o), 32'h1);
        check("req_stall", 32'(core_stall_o), 32'h1);
        check("req_err", 32'(core_err_o), 32'h0);
        check("mem_be", 32'(mem_be_o), model_be(size, addr));
        @(posedge clk_i);
        #1;
        // Core inputs wander during WAIT; the latched request must govern completion.
        core_req_i  = 1'($urandom_range(0, 1));
        core_we_i   = 1'($urandom_range(0, 1));
        core_size_i = 3'($urandom_range(0, 7));
        core_addr_i = $urandom;
        done = 1'b0;
        for (int w = 0; w <= int'(T); w++) begin
            if (w < lat) begin
                mem_ready_i = 1'b0;
                mem_rd_i    = $urandom;
            end else begin
                mem_ready_i = 1'b1;
                mem_rd_i    = word;
            end
            if (w >= lat || w == int'(T)) core_req_i = 1'b0;
            @(negedge clk_i);
            check("wait_req", 32'(mem_req_o), 32'h0);
            if (w >= lat) begin
                check("done_rd", core_rd_o, we ? 32'h0 : model_load(size, addr, word));
                check("done_stall", 32'(core_stall_o), 32'h0);
                check("done_err", 32'(core_err_o), 32'h0);
                done = 1'b1;
            end else if (w == int'(T)) begin
                check("to_err", 32'(core_err_o), 32'h1);
                check("to_stall", 32'(core_stall_o), 32'h0);
                check("to_rd", core_rd_o, 32'h0);
                done = 1'b1;
            end else begin
                check("wait_stall", 32'(core_stall_o), 32'h1);
                check("wait_err", 32'(core_err_o), 32'h0);
                check("wait_rd", core_rd_o, 32'h0);
            end
            @(posedge clk_i);
            #1;
            if (done) break;
        end
        mem_ready_i = 1'b0;
        core_req_i  = 1'b0;
    endtask

    // An IDLE cycle with no request and mem_ready_i high must produce nothing.
    task automatic idle_ready_step();
        core_req_i  = 1'b0;
        mem_ready_i = 1'b1;
        mem_rd_i    = $urandom;
        @(negedge clk_i);
        check("idle_rd", core_rd_o, 32'h0);
        check("idle_err", 32'(core_err_o), 32'h0);
        check("idle_stall", 32'(core_stall_o), 32'h0);
        check("idle_req", 32'(mem_req_o), 32'h0);
        @(posedge clk_i);
        #1;
        mem_ready_i = 1'b0;
    endtask

    initial begin
        logic [2:0] legal_sizes [5];
        logic [2:0] bad_sizes   [3];
        legal_sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bad_sizes   = '{3'd3, 3'd6, 3'd7};

        // Reset with a live legal request and a ready memory: everything forced quiet.
        rst_i       = 1'b1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h100;
        core_wd_i   = 32'h0;
        mem_rd_i    = 32'h1234_5678;
        mem_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_req", 32'(mem_req_o), 32'h0);
        check("rst_be", 32'(mem_be_o), 32'h0);
        check("rst_stall", 32'(core_stall_o), 32'h0);
        check("rst_err", 32'(core_err_o), 32'h0);
        check("rst_rd", core_rd_o, 32'h0);
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;

        // Directed examples, issued back to back.
        access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0);
        access(1'b0, 3'd5, 32'h102, 32'h0, 32'h8001_ABCD, 0);
        access(1'b1, 3'd1, 32'h202, 32'hDEAD_BEEF, 32'h0, 0);
        access(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
        access(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0);
        access(1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFE_F00D, 2);
        access(1'b0, 3'd2, 32'h304, 32'h0, 32'h0, int'(T) + 5);
        idle_ready_step();

        // Reset while in WAIT: no error, later ready ignored, next load normal.
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h400;
        @(posedge clk_i);
        #1;
        core_req_i  = 1'b0;
        rst_i       = 1'b1;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        check("rstw_err", 32'(core_err_o), 32'h0);
        check("rstw_stall", 32'(core_stall_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle_ready_step();
        access(1'b0, 3'd2, 32'h400, 32'h0, 32'h1357_9BDF, 0);

        // Randomized accesses against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  s;
            logic [31:0] a;
            int          lat;
            int unsigned nb;
            if ($urandom_range(0, 9) < 8) s = legal_sizes[$urandom_range(0, 4)];
            else                          s = bad_sizes[$urandom_range(0, 2)];
            a  = $urandom;
            nb = size_bytes(s);
            if (nb != 0 && $urandom_range(0, 3) != 0) a = a - (a % nb);
            lat = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) lat = int'(T) + $urandom_range(1, 3);
            access(1'($urandom_range(0, 1)), s, a, $urandom, $urandom, lat);
            if ($urandom_range(0, 7) == 0) idle_ready_step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
